// File: rtl/seq_accum16.sv
// seq_accum16: sequential block accumulator feeding a 16-bit carry-lookahead
// adder (cla16, also defined in this file). It takes a programmed number of
// operands over a valid/ready stream and adds each accepted operand to a
// running sum. It returns the sum and a sticky carry-out flag on a valid/ready
// result port.
//
// Build option: define SEQ_ACCUM16_SATURATE_EN to clamp the running sum at
// 16'hFFFF on carry-out instead of wrapping. The port list is the same in both
// builds.

// 16-bit carry-lookahead adder: four 4-bit groups joined by a second-level
// lookahead on group generate/propagate.
module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;

  assign g = a & b;
  assign p = a ^ b;

  // group generate / propagate for each nibble
  always_comb begin
    gg = '0;
    gp = '0;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
  end

  // second-level lookahead: carry into each nibble directly from cin
  always_comb begin
    gc    = '0;
    gc[0] = cin;
    gc[1] = gg[0] | (gp[0] & cin);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & cin);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
  end

  // in-group carries expanded from the nibble carry-in
  always_comb begin
    c = '0;
    for (int k = 0; k < 4; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
  end

  assign sum  = p ^ c;
  assign cout = gc[4];

endmodule

// State table
//   state | meaning
//   IDLE  | waiting for start; in_ready and out_valid low
//   ACCUM | accepting operands, one per beat, until rem reaches zero
//   DONE  | presenting out_sum/out_ovf until out_ready
module seq_accum16 #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovf,
  output logic             busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] acc;
  logic             ovf;
  logic [CNT_W-1:0] rem;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             accept;

  // carry-in is tied low: every beat is a plain acc + operand
  cla16 u_cla16 (
    .a    (acc),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // handshake outputs come from registered state only, so there is no
  // combinational path from in_valid or out_ready back to them
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_sum   = acc;
  assign out_ovf   = ovf;
  assign accept    = in_valid & in_ready;

  // block sequencing, accumulation and the sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
      rem   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc <= '0;
            ovf <= 1'b0;
            if (len != '0) begin
              rem   <= len;
              state <= ACCUM;
            end else begin
              state <= DONE;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
`ifdef SEQ_ACCUM16_SATURATE_EN
            acc <= add_cout ? {WIDTH{1'b1}} : add_sum;
`else
            acc <= add_sum;
`endif
            ovf <= ovf | add_cout;
            rem <= rem - 1'b1;
            if (rem == CNT_W'(1)) state <= DONE;
          end
        end
        DONE: begin
          // a start arriving with out_ready is ignored; only IDLE samples it
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_accum16.sv
// Self-checking bench for seq_accum16: a block-level reference model plus
// directed literal checks and randomized blocks.
module tb_seq_accum16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_ovf;
  logic        busy;

  int checks = 0;
  int errors = 0;

  seq_accum16 #(.WIDTH(16), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

`ifdef SEQ_ACCUM16_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // Block-level model: collects the operands of the open block and
  // computes the result from them with plain integer arithmetic.
  bit          m_open;
  bit          m_done;
  int          m_len;
  logic [15:0] m_ops[$];

  function automatic logic [16:0] ref_result(input logic [15:0] ops[$]);
    int total;
    bit carry;
    total = 0;
    carry = 1'b0;
    foreach (ops[i]) begin
      total = total + int'(ops[i]);
      if (total > 65535) begin
        carry = 1'b1;
        total = SAT ? 65535 : total - 65536;
      end
    end
    return {carry, total[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, compare the DUT against the model, then advance the model
  // with the inputs that the next rising edge will see.
  always @(negedge clk) begin
    logic [16:0] r;
    if (rst) begin
      m_open = 1'b0;
      m_done = 1'b0;
      m_len  = 0;
      m_ops.delete();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_out_sum", 32'(out_sum), 32'd0);
      chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    end else begin
      chk("m_in_ready", 32'(in_ready), 32'(m_open));
      chk("m_out_valid", 32'(out_valid), 32'(m_done));
      chk("m_busy", 32'(busy), 32'(m_open | m_done));
      if (m_done) begin
        r = ref_result(m_ops);
        chk("m_out_sum", 32'(out_sum), 32'(r[15:0]));
        chk("m_out_ovf", 32'(out_ovf), 32'(r[16]));
      end
      if (m_done) begin
        if (out_ready) m_done = 1'b0;
      end else if (m_open) begin
        if (in_valid) begin
          m_ops.push_back(in_data);
          if (m_ops.size() == m_len) begin
            m_open = 1'b0;
            m_done = 1'b1;
          end
        end
      end else if (start) begin
        m_ops.delete();
        m_len = int'(len);
        if (len == 8'd0) m_done = 1'b1;
        else m_open = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_block(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  // Present one operand and keep in_valid high until it is accepted.
  task automatic send(input logic [15:0] d);
    bit taken;
    int budget;
    in_valid = 1'b1;
    in_data  = d;
    budget   = 0;
    do begin
      taken = in_ready;
      tick();
      budget++;
    end while (!taken && budget < 50);
    if (!taken) begin
      errors++;
      $display("FAIL send_timeout: operand 0x%0h not accepted", d);
    end
  endtask

  // Wait for the result, compare it with literal values, hold it for
  // `hold` cycles (optionally spamming start), then hand it off.
  task automatic get_result(input string name, input logic [15:0] es, input bit eo,
                            input int hold, input bit spam, input bit hs_start);
    int budget;
    budget = 0;
    while (!out_valid && budget < 300) begin
      tick();
      budget++;
    end
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_sum"}, 32'(out_sum), 32'(es));
    chk({name, "_ovf"}, 32'(out_ovf), 32'(eo));
    for (int i = 0; i < hold; i++) begin
      start = spam;
      len   = 8'd9;
      tick();
    end
    start     = hs_start;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    chk({name, "_drop"}, 32'(out_valid), 32'd0);
  endtask

  // Randomized block: random length, gaps, start spam and result delay.
  task automatic random_block();
    int l;
    int sent;
    int budget;
    int wait_n;
    bit taken;
    l = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12));
    start_block(8'(l));
    sent   = 0;
    budget = 0;
    while (sent < l && budget < 2000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: in_data = 16'h0000;
        1: in_data = 16'(32'hFF00 + $urandom_range(0, 255));
        default: in_data = 16'($urandom);
      endcase
      start = ($urandom_range(0, 4) == 0);
      len   = 8'($urandom);
      taken = in_valid & in_ready;
      tick();
      if (taken) sent++;
      budget++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (sent < l) begin
      errors++;
      $display("FAIL rand_timeout: sent %0d of %0d", sent, l);
    end
    budget = 0;
    while (!out_valid && budget < 20) begin
      tick();
      budget++;
    end
    chk("rand_result_valid", 32'(out_valid), 32'd1);
    wait_n = $urandom_range(0, 4);
    for (int i = 0; i < wait_n; i++) begin
      start = ($urandom_range(0, 1) == 0);
      tick();
    end
    start     = ($urandom_range(0, 1) == 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    repeat ($urandom_range(0, 2)) tick();
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    len       = 8'd0;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    out_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // 1 + 2 + 3 with in_valid held high
    start_block(8'd3);
    send(16'h0001);
    send(16'h0002);
    send(16'h0003);
    in_valid = 1'b0;
    chk("t1_latency", 32'(out_valid), 32'd1);
    get_result("t1", 16'h0006, 1'b0, 0, 1'b0, 1'b0);
    tick();

    // carry out of bit 15
    start_block(8'd2);
    send(16'hFFFF);
    send(16'h0002);
    in_valid = 1'b0;
    get_result("t2", SAT ? 16'hFFFF : 16'h0001, 1'b1, 0, 1'b0, 1'b0);
    tick();

    // empty block: result one cycle after start, no operand phase
    start_block(8'd0);
    chk("t3_latency", 32'(out_valid), 32'd1);
    chk("t3_in_ready", 32'(in_ready), 32'd0);
    get_result("t3", 16'h0000, 1'b0, 0, 1'b0, 1'b0);
    tick();

    // toggling in_valid, start spam in ACCUM and DONE, delayed out_ready,
    // start coincident with the DONE->IDLE handoff
    start_block(8'd4);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h1000;
      start    = 1'b1;
      len      = 8'd7;
      tick();
      in_valid = 1'b0;
      start    = 1'b0;
      if (i < 3) tick();
    end
    get_result("t4", 16'h4000, 1'b0, 5, 1'b1, 1'b1);
    chk("t4_idle_busy", 32'(busy), 32'd0);
    tick();

    // reset mid-block after two accepted operands (acc and ovf both dirty)
    start_block(8'd4);
    send(16'hFFFF);
    send(16'hFFFF);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    chk("t5_rst_sum", 32'(out_sum), 32'd0);
    chk("t5_rst_ovf", 32'(out_ovf), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    start_block(8'd1);
    send(16'h00AA);
    in_valid = 1'b0;
    get_result("t5", 16'h00AA, 1'b0, 0, 1'b0, 1'b0);

    // back-to-back blocks: start right after the result handshake
    start_block(8'd2);
    send(16'hFFFF);
    send(16'h0003);
    in_valid = 1'b0;
    get_result("t6a", SAT ? 16'hFFFF : 16'h0002, 1'b1, 0, 1'b0, 1'b0);
    start_block(8'd3);
    send(16'h0001);
    send(16'h0001);
    send(16'h0001);
    in_valid = 1'b0;
    get_result("t6b", 16'h0003, 1'b0, 0, 1'b0, 1'b0);
    tick();

    for (int n = 0; n < 40; n++) random_block();

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_accum16.md
Name: seq_accum16

Overview:
- Sequential accumulator that sits directly upstream of, and drives, the team's 16-bit carry-lookahead adder (CLA16).
- Accepts a programmed number of 16-bit operands over a valid/ready stream and adds each one to a running sum through a single CLA16 instance, with cin tied to 0.
- Presents the final sum and an overflow flag on a valid/ready result port.
- Used for checksums and block sums.

Parameters:
- WIDTH, 16, datapath width; fixed at 16 to match CLA16; other values unsupported.
- CNT_W, 8, width of the length field; maximum operands per block is 2^CNT_W - 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  one-cycle pulse that begins a block; sampled only in IDLE
- len  input  CNT_W  number of operands in the block; sampled with start
- in_valid  input  1  operand valid
- in_ready  output  1  operand accepted when in_valid & in_ready
- in_data  input  WIDTH  operand
- out_valid  output  1  result valid
- out_ready  input  1  result consumed when out_valid & out_ready
- out_sum  output  WIDTH  accumulated sum
- out_ovf  output  1  carry out of bit 15 occurred at least once in the block
- busy  output  1  high in ACCUM or DONE

Behaviour:
- Reset: asynchronous, active-high. State goes to IDLE, and acc, remaining count, out_sum, out_ovf, out_valid, in_ready and busy are all forced to 0. Reset asserted mid-block aborts the block with no result.
- The adder sees a = acc, b = in_data, cin = 0. Its sum and cout are captured only on an accepted beat.
- IDLE:
  - in_ready = 0, out_valid = 0.
  - start = 1 and len != 0: acc <- 0, ovf <- 0, rem <- len, go to ACCUM.
  - start = 1 and len == 0: acc <- 0, ovf <- 0, go to DONE. out_valid rises next cycle with sum 0 and ovf 0.
- ACCUM:
  - in_ready = 1.
  - On an accepted beat: acc <- sum, ovf <- ovf | cout, rem <- rem - 1.
  - When the accepted beat has rem == 1, go to DONE.
  - in_valid low: hold everything.
- DONE:
  - out_valid = 1, out_sum = acc, out_ovf = ovf; in_ready = 0.
  - Outputs are stable while out_valid & !out_ready.
  - On out_ready go to IDLE; out_valid drops next cycle.
- Latency: out_valid is high in the cycle after the last operand is accepted. Throughput is 1 operand per clock in ACCUM. Minimum block overhead is 1 start cycle plus 1 result cycle.
- start outside IDLE is ignored, and len is ignored with it.
- start in the same cycle that DONE hands off to IDLE is ignored; it takes effect only when sampled in IDLE.
- Arithmetic: modulo 2^16 wrap by default. ovf is sticky within a block and cleared on each start.
- No combinational path from in_valid to in_ready or from out_ready to out_valid. in_ready and out_valid are decoded from registered state only.

Optional Feature:
- Macro: SEQ_ACCUM16_SATURATE_EN.
- Defined: on an accepted beat with cout = 1, acc <- 16'hFFFF instead of the wrapped sum, and ovf is set. Later beats keep adding from 16'hFFFF, so the sum stays saturated: any nonzero operand produces cout again, and a zero operand leaves acc unchanged.
- Not defined: plain wrap; ovf is still reported.
- Port list is identical in both builds.

Test Plan:
- Reset, then start with len = 3 and operands 0x0001, 0x0002, 0x0003 with in_valid held high -> out_valid high the cycle after the third accept; out_sum = 0x0006, out_ovf = 0.
- len = 2 with operands 0xFFFF, 0x0002 -> wrap build: out_sum = 0x0001, out_ovf = 1. SATURATE_EN build: out_sum = 0xFFFF, out_ovf = 1.
- len = 0 -> out_valid one cycle after start; out_sum = 0x0000, out_ovf = 0; in_ready never rises.
- len = 4 with in_valid toggling 1,0,1,0,... (operands 0x1000 each) and out_ready held low 5 cycles -> out_sum = 0x4000; result held stable until out_ready; start pulses during ACCUM/DONE ignored.
- Assert rst for 1 cycle after 2 of 4 operands accepted -> all outputs 0 immediately; a new start with len = 1 and operand 0x00AA gives out_sum = 0x00AA, proving acc and ovf were cleared.
- Back-to-back blocks with start asserted the cycle after the out_valid & out_ready handshake -> second block sum independent of the first; ovf from the first block not carried over.
